alu_seq_ctrl: RTL and testbench

Multi-cycle sequencer that executes NIBBLES×4-bit-wide ALU operations on a single 4-bit ALU slice, one nibble per cycle, least-significant nibble first. It chains carry/borrow between nibbles. A valid/ready handshake sits on both the operation input and the result output. It sits between an operand/op source (register file or test front-end) and the shared 4-bit ALU datapath.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_slice4.sv | 40 ++++
 rtl/alu_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: op codes, FSM
// states and a helper that classifies the select code.
package alu_seq_pkg;

  // {S1,S0,M} encodings
  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef enum logic [1:0] {CLS_LOGIC, CLS_ARITH, CLS_INVALID} op_cls_t;

  // Latched operation request
  typedef struct packed {
    logic [2:0] sel;
    logic       cin;
  } op_req_t;

  function automatic op_cls_t op_class(input logic [2:0] sel);
    case (sel)
      OP_ADD, OP_SUB:                 op_class = CLS_ARITH;
      OP_NOT, OP_AND, OP_OR, OP_XOR:  op_class = CLS_LOGIC;
      default:                        op_class = CLS_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/alu_slice4.sv
// Combinational 4-bit ALU slice. Logic ops and invalid codes never
// produce a carry, so the chain is naturally broken for them.
module alu_slice4
  import alu_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] sel,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);

  logic [4:0] sum;

  // One nibble of the selected function; bit 4 of the 5-bit result is carry/borrow
  always_comb begin
    sum  = '0;
    y    = '0;
    cout = 1'b0;
    case (sel)
      OP_NOT: y = ~a;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        y    = sum[3:0];
        cout = sum[4];
      end
      OP_SUB: begin
        sum  = {1'b0, a} - {1'b0, b} - {4'b0, cin};
        y    = sum[3:0];
        cout = sum[4];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Nibble-serial ALU sequencer: accepts a W-bit op, runs it LSB nibble first
// through one alu_slice4 with a registered carry chain, then holds the result
// until the consumer takes it.
// Optional: define ALU_SEQ_ZFLAG_EN to add the out_zero result flag.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter  int NIBBLES = 2,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_sel,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic         out_cout
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic         out_zero
`endif
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q, b_q;
  op_req_t       req_q;
  logic          carry;
  logic [3:0]    s_a, s_b, s_y;
  logic          s_cin, s_cout, s_zero;
`ifdef ALU_SEQ_ZFLAG_EN
  logic          zacc;
`endif

  assign s_a    = a_q[{idx, 2'b00} +: 4];
  assign s_b    = b_q[{idx, 2'b00} +: 4];
  assign s_cin  = (idx == '0) ? req_q.cin : carry;
  assign s_zero = (s_y == 4'h0);

  alu_slice4 u_slice (
    .a    (s_a),
    .b    (s_b),
    .sel  (req_q.sel),
    .cin  (s_cin),
    .y    (s_y),
    .cout (s_cout)
  );

  // Sequencer FSM: accept, step one nibble per cycle, hold result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      req_q     <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_cout  <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
      zacc      <= 1'b0;
      out_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q       <= in_a;
          b_q       <= in_b;
          req_q.sel <= in_sel;
          req_q.cin <= in_cin;
          idx       <= '0;
          in_ready  <= 1'b0;
          state     <= EXEC;
`ifdef ALU_SEQ_ZFLAG_EN
          zacc      <= 1'b1;
`endif
        end
        EXEC: begin
          out_y[{idx, 2'b00} +: 4] <= s_y;
          // only arithmetic ops may propagate a carry into the next nibble
          carry <= (op_class(req_q.sel) == CLS_ARITH) & s_cout;
          idx   <= idx + IW'(1);
`ifdef ALU_SEQ_ZFLAG_EN
          zacc  <= zacc & s_zero;
`endif
          if (idx == LAST) begin
            out_cout  <= s_cout;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef ALU_SEQ_ZFLAG_EN
            out_zero  <= zacc & s_zero;
`endif
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
`ifdef ALU_SEQ_ZFLAG_EN
          out_zero  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ALU_SEQ_ZFLAG_EN
  logic unused_zero;
  assign unused_zero = s_zero;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl (NIBBLES=2): vector table plus
// hand-written backpressure and mid-operation reset sequences.
module tb_alu_seq_ctrl;

  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   in_sel;
  logic         in_cin;
  logic         out_valid, out_ready;
  logic [W-1:0] out_y;
  logic         out_cout;
`ifdef ALU_SEQ_ZFLAG_EN
  logic         out_zero;
`endif

  int tests = 0;
  int fails = 0;

  alu_seq_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_cout  (out_cout)
`ifdef ALU_SEQ_ZFLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] sel;
    logic       cin;
    logic [7:0] y;
    logic       cout;
    logic       z;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for the result, check it, then hand it off
  task automatic run_op(input int id, input vec_t v);
    int lat;
    lat = 0;
    while (!in_ready && lat < 20) begin tick(); lat++; end
    chk($sformatf("v%0d in_ready", id), {31'b0, in_ready}, 32'd1);
    in_a = v.a; in_b = v.b; in_sel = v.sel; in_cin = v.cin; in_valid = 1'b1;
    tick();                       // accept edge
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk($sformatf("v%0d latency", id), lat, N);
    chk($sformatf("v%0d y", id), {24'b0, out_y}, {24'b0, v.y});
    chk($sformatf("v%0d cout", id), {31'b0, out_cout}, {31'b0, v.cout});
`ifdef ALU_SEQ_ZFLAG_EN
    chk($sformatf("v%0d zero", id), {31'b0, out_zero}, {31'b0, v.z});
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("v%0d release", id), {30'b0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    //        a      b      sel     cin   y      cout  z
    vt[0]  = '{8'h3C, 8'h4F, 3'b001, 1'b0, 8'h8B, 1'b0, 1'b0};  // ADD
    vt[1]  = '{8'hFF, 8'h01, 3'b001, 1'b1, 8'h01, 1'b1, 1'b0};  // ADD, carry through
    vt[2]  = '{8'h10, 8'h01, 3'b011, 1'b0, 8'h0F, 1'b0, 1'b0};  // SUB, borrow nibble 0
    vt[3]  = '{8'h01, 8'h02, 3'b011, 1'b0, 8'hFF, 1'b1, 1'b0};  // SUB underflow
    vt[4]  = '{8'h55, 8'h55, 3'b011, 1'b0, 8'h00, 1'b0, 1'b1};  // SUB equal
    vt[5]  = '{8'hA5, 8'h00, 3'b000, 1'b0, 8'h5A, 1'b0, 1'b0};  // NOT
    vt[6]  = '{8'hF0, 8'h3C, 3'b110, 1'b0, 8'hCC, 1'b0, 1'b0};  // XOR
    vt[7]  = '{8'h12, 8'h34, 3'b101, 1'b1, 8'h00, 1'b0, 1'b1};  // invalid sel
    vt[8]  = '{8'h3C, 8'h0F, 3'b010, 1'b0, 8'h0C, 1'b0, 1'b0};  // AND
    vt[9]  = '{8'h30, 8'h05, 3'b100, 1'b0, 8'h35, 1'b0, 1'b0};  // OR
    vt[10] = '{8'h00, 8'h00, 3'b011, 1'b1, 8'hFF, 1'b1, 1'b0};  // SUB borrow-in
    vt[11] = '{8'h80, 8'h80, 3'b001, 1'b0, 8'h00, 1'b1, 1'b1};  // ADD overflow to zero
    vt[12] = '{8'hF0, 8'h0F, 3'b010, 1'b1, 8'h00, 1'b0, 1'b1};  // AND ignores cin

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sel = '0; in_cin = 1'b0;
    tick(); tick();
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_y", {24'b0, out_y}, 32'd0);
    chk("reset out_cout", {31'b0, out_cout}, 32'd0);
`ifdef ALU_SEQ_ZFLAG_EN
    chk("reset out_zero", {31'b0, out_zero}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_op(i, vt[i]);

    // Backpressure: result held, new requests ignored while DONE
    in_a = 8'h3C; in_b = 8'h4F; in_sel = 3'b001; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bp exec in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("bp out_valid", {31'b0, out_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_a = 8'(c * 37 + 5); in_b = 8'(c * 11 + 9); in_sel = 3'b011;
      tick();
      chk($sformatf("bp%0d y", c), {24'b0, out_y}, 32'h8B);
      chk($sformatf("bp%0d hs", c), {29'b0, out_cout, in_ready, out_valid}, 32'b001);
    end
    out_ready = 1'b1;             // in_valid still high at the release edge
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp release", {30'b0, in_ready, out_valid}, 32'b10);
    tick();
    chk("bp no accept", {30'b0, in_ready, out_valid}, 32'b10);

    // Reset mid-EXEC after nibble 0
    in_a = 8'h77; in_b = 8'h11; in_sel = 3'b001; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst mid in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst mid out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst mid out_y", {24'b0, out_y}, 32'd0);
    tick(); tick(); tick();
    chk("rst mid no result", {31'b0, out_valid}, 32'd0);
    run_op(99, '{8'h01, 8'h01, 3'b001, 1'b0, 8'h02, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
